// File: rtl/duck_sprite_gen.sv
// duck_sprite_gen
//   Owns one duck: flight FSM, position and animation frame, all advanced once
//   per video frame (rising edge of frame_clk). Every pixel clock it maps the
//   current DrawX/DrawY to is_duck and a duckROM address for color_mapper, and
//   it reports escape / kill events to the game controller.
//
// Ports
//   Clk          system clock, rising-edge active
//   Reset        asynchronous, active-high; clears all state
//   frame_clk    vsync-derived level; rising edge = frame tick
//   state[1:0]   game state: 00 title, 01/10 in game, 11 over
//   shot         one-cycle pulse: the shooter hit this duck
//   DrawX/DrawY  current pixel coordinates
//   is_duck      registered: current pixel is inside the sprite box
//   duck_addr    registered: {af, row, col} into duckROM, 0 outside the box
//   duck_x/y     sprite top-left corner
//   duck_escaped one-cycle pulse as an escaping duck returns to IDLE
//   duck_dead    one-cycle pulse as a falling duck returns to IDLE
module duck_sprite_gen #(
  parameter int FLY_FRAMES = 600,
  parameter int HIT_FRAMES = 30,
  parameter int SPR        = 64,
  parameter int X_MAX      = 575,
  parameter int Y_GROUND   = 416
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [1:0]  state,
  input  logic        shot,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic        is_duck,
  output logic [15:0] duck_addr,
  output logic [9:0]  duck_x,
  output logic [9:0]  duck_y,
  output logic        duck_escaped,
  output logic        duck_dead
);

  typedef enum logic [2:0] {S_IDLE, S_FLY, S_ESCAPE, S_HIT, S_FALL} fsm_t;

  localparam int                 SPR_W     = $clog2(SPR);
  localparam logic [9:0]         X_SPAWN   = 10'd288;
  localparam logic [9:0]         Y_GND     = 10'(Y_GROUND);
  localparam logic [9:0]         FALL_LIM  = 10'(Y_GROUND - 3);
  localparam logic [9:0]         FLY_LAST  = 10'(FLY_FRAMES - 1);
  localparam logic [9:0]         HIT_LAST  = 10'(HIT_FRAMES - 1);
  localparam logic [9:0]         SPR_L     = 10'(SPR);
  localparam logic signed [10:0] X_MAX_S   = 11'(X_MAX);
  localparam logic signed [10:0] Y_GND_S   = 11'(Y_GROUND);

  fsm_t              fsm_q, fsm_d;
  logic [9:0]        x_q, x_d, y_q, y_d, cnt_q, cnt_d;
  logic signed [2:0] vx_q, vx_d, vy_q, vy_d;
  logic [2:0]        af_q, af_d, af_cyc;
  logic              dir_q, dir_d;   // 0: next spawn flies right
  logic              esc_d, dead_d;
  logic              fc_d, tick, in_game;
  logic signed [10:0] nx, ny;
  logic [9:0]        dx, dy;
  logic              hit_box;

  assign tick    = frame_clk & ~fc_d;
  assign in_game = (state == 2'b01) || (state == 2'b10);

  // Positions are unsigned 10-bit; widen to 11-bit signed so a step past
  // either edge shows up as negative or above the limit.
  assign nx = $signed({1'b0, x_q}) + $signed({{8{vx_q[2]}}, vx_q});
  assign ny = $signed({1'b0, y_q}) + $signed({{8{vy_q[2]}}, vy_q});

  // Wing-beat frame for FLY/ESCAPE: 0 -> 1 -> 2 -> 0, one step every 8 ticks.
  assign af_cyc = (cnt_q[2:0] != 3'd7) ? af_q :
                  (af_q >= 3'd2)       ? 3'd0 : af_q + 3'd1;

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    fsm_d  = fsm_q;
    x_d    = x_q;
    y_d    = y_q;
    vx_d   = vx_q;
    vy_d   = vy_q;
    af_d   = af_q;
    dir_d  = dir_q;
    cnt_d  = cnt_q;
    esc_d  = 1'b0;
    dead_d = 1'b0;

    if (!in_game) begin
      // Leaving the game drops straight to IDLE without any event.
      fsm_d = S_IDLE;
      cnt_d = '0;
    end else begin
      case (fsm_q)
        S_IDLE: if (tick) begin
          fsm_d = S_FLY;
          cnt_d = '0;
          x_d   = X_SPAWN;
          y_d   = Y_GND;
          vy_d  = -3'sd1;
          vx_d  = dir_q ? -3'sd2 : 3'sd2;
          dir_d = ~dir_q;
          af_d  = 3'd0;
        end

        S_FLY: if (shot) begin
          // A shot on a tick wins: the duck freezes where it is.
          fsm_d = S_HIT;
          cnt_d = '0;
          af_d  = 3'd3;
        end else if (tick) begin
          if (nx[10]) begin
            x_d  = '0;
            vx_d = -vx_q;
          end else if (nx > X_MAX_S) begin
            x_d  = X_MAX_S[9:0];
            vx_d = -vx_q;
          end else begin
            x_d = nx[9:0];
          end
          if (ny[10]) begin
            y_d  = '0;
            vy_d = -vy_q;
          end else if (ny > Y_GND_S) begin
            y_d  = Y_GND;
            vy_d = -vy_q;
          end else begin
            y_d = ny[9:0];
          end
          af_d = af_cyc;
          if (cnt_q == FLY_LAST) begin
            fsm_d = S_ESCAPE;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end

        S_ESCAPE: if (shot) begin
          fsm_d = S_HIT;
          cnt_d = '0;
          af_d  = 3'd3;
        end else if (tick) begin
          vx_d  = 3'sd0;
          af_d  = af_cyc;
          cnt_d = cnt_q + 10'd1;
          if (y_q <= 10'd3) begin
            y_d   = '0;
            esc_d = 1'b1;
            fsm_d = S_IDLE;
          end else begin
            y_d = y_q - 10'd3;
          end
        end

        S_HIT: if (tick) begin
          if (cnt_q == HIT_LAST) begin
            fsm_d = S_FALL;
            cnt_d = '0;
            af_d  = 3'd4;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end

        S_FALL: if (tick) begin
          cnt_d = cnt_q + 10'd1;
          if (cnt_q[1:0] == 2'd3) af_d = (af_q == 3'd4) ? 3'd5 : 3'd4;
          if (y_q >= FALL_LIM) begin
            y_d    = Y_GND;
            dead_d = 1'b1;
            fsm_d  = S_IDLE;
          end else begin
            y_d = y_q + 10'd3;
          end
        end

        default: fsm_d = S_IDLE;
      endcase
    end
  end

  // Unsigned 10-bit differences wrap for pixels left of / above the sprite,
  // so a single "< SPR" test covers both sides of the box.
  assign dx      = DrawX - x_q;
  assign dy      = DrawY - y_q;
  assign hit_box = (dx < SPR_L) && (dy < SPR_L) && (fsm_q != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fc_d         <= 1'b0;
      fsm_q        <= S_IDLE;
      cnt_q        <= '0;
      x_q          <= X_SPAWN;
      y_q          <= Y_GND;
      vx_q         <= 3'sd0;
      vy_q         <= 3'sd0;
      af_q         <= 3'd0;
      dir_q        <= 1'b0;
      duck_escaped <= 1'b0;
      duck_dead    <= 1'b0;
      is_duck      <= 1'b0;
      duck_addr    <= '0;
    end else begin
      fc_d         <= frame_clk;
      fsm_q        <= fsm_d;
      cnt_q        <= cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      vx_q         <= vx_d;
      vy_q         <= vy_d;
      af_q         <= af_d;
      dir_q        <= dir_d;
      duck_escaped <= esc_d;
      duck_dead    <= dead_d;
      is_duck      <= hit_box;
      duck_addr    <= hit_box ? {1'b0, af_q, dy[SPR_W-1:0], dx[SPR_W-1:0]} : '0;
    end
  end

  assign duck_x = x_q;
  assign duck_y = y_q;

endmodule

// File: tb/tb_duck_sprite_gen.sv
// Directed bench for duck_sprite_gen: spawn, wall bounce, escape, shot/HIT/FALL
// with animation frames, shot ignored in IDLE, async reset and game exit.
module tb_duck_sprite_gen;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic [1:0]  state = 2'b00;
  logic        shot = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        is_duck;
  logic [15:0] duck_addr;
  logic [9:0]  duck_x, duck_y;
  logic        duck_escaped, duck_dead;

  int checks = 0;
  int failures = 0;
  int esc_cnt = 0;
  int dead_cnt = 0;

  duck_sprite_gen dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .state        (state),
    .shot         (shot),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .is_duck      (is_duck),
    .duck_addr    (duck_addr),
    .duck_x       (duck_x),
    .duck_y       (duck_y),
    .duck_escaped (duck_escaped),
    .duck_dead    (duck_dead)
  );

  always #5 Clk = ~Clk;

  // Count high cycles of each event so a stretched pulse is caught too.
  always @(negedge Clk) begin
    if (duck_escaped === 1'b1) esc_cnt++;
    if (duck_dead === 1'b1) dead_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic do_tick();
    @(negedge Clk); frame_clk = 1'b1;
    @(negedge Clk); frame_clk = 1'b0;
    @(negedge Clk);
  endtask

  task automatic shot_tick();
    @(negedge Clk); frame_clk = 1'b1; shot = 1'b1;
    @(negedge Clk); frame_clk = 1'b0; shot = 1'b0;
    @(negedge Clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic pulse_shot();
    @(negedge Clk); shot = 1'b1;
    @(negedge Clk); shot = 1'b0;
  endtask

  task automatic pos(input string tag, input logic [9:0] ex, input logic [9:0] ey);
    check({tag, "_x"}, duck_x, ex);
    check({tag, "_y"}, duck_y, ey);
  endtask

  task automatic pix(input string tag, input logic [9:0] px, input logic [9:0] py,
                     input logic exp_hit, input logic [15:0] exp_addr);
    @(negedge Clk); DrawX = px; DrawY = py;
    @(negedge Clk);
    check({tag, "_hit"}, is_duck, exp_hit);
    check({tag, "_addr"}, duck_addr, exp_addr);
  endtask

  initial begin
    int n;

    // Reset state
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    pos("rst", 10'd288, 10'd416);
    check("rst_is_duck", is_duck, 1'b0);
    check("rst_addr", duck_addr, 16'h0);
    check("rst_esc", duck_escaped, 1'b0);
    check("rst_dead", duck_dead, 1'b0);
    pix("idle_box", 10'd288, 10'd416, 1'b0, 16'h0);

    // Duck 1: spawn flying right
    state = 2'b01;
    do_tick();
    pos("spawn1", 10'd288, 10'd416);
    pix("spawn1_pix", 10'd288, 10'd416, 1'b1, 16'h0);
    do_tick();                                   // k=1
    pos("fly1", 10'd290, 10'd415);
    pix("corner", 10'd290, 10'd415, 1'b1, 16'h0);
    pix("left_out", 10'd289, 10'd415, 1'b0, 16'h0);
    pix("r2c2", 10'd292, 10'd417, 1'b1, 16'h0082);
    pix("above_out", 10'd290, 10'd414, 1'b0, 16'h0);

    ticks(142);                                  // k=143, af=17 mod 3 = 2
    pos("k143", 10'd574, 10'd273);
    pix("af2_corner", 10'd574, 10'd273, 1'b1, 16'h2000);
    pix("af2_far", 10'd637, 10'd336, 1'b1, 16'h2FFF);
    pix("right_out", 10'd638, 10'd273, 1'b0, 16'h0);
    do_tick();                                   // clamp at X_MAX, vx -> -2
    pos("bounce", 10'd575, 10'd272);
    do_tick();
    pos("after_bounce", 10'd573, 10'd271);

    // Run to the end of FLY: x bounced at 0 (k=432), y bounced at 0 (k=417)
    ticks(455);                                  // k=600
    pos("k600", 10'd336, 10'd183);
    check("no_esc_yet", esc_cnt, 0);
    do_tick();                                   // first ESCAPE tick
    pos("esc1", 10'd336, 10'd180);
    n = 1;
    while (esc_cnt == 0 && n < 100) begin
      do_tick();
      n++;
    end
    check("esc_ticks", n, 61);
    check("esc_pulses", esc_cnt, 1);
    pos("escaped", 10'd336, 10'd0);
    check("esc_no_dead", dead_cnt, 0);
    pix("esc_idle", 10'd336, 10'd0, 1'b0, 16'h0);

    // Duck 2: flies left, shot on a tick, HIT, FALL, dead
    do_tick();
    pos("spawn2", 10'd288, 10'd416);
    do_tick();
    pos("fly2_left", 10'd286, 10'd415);
    ticks(214);                                  // k=215
    pos("k215", 10'd140, 10'd201);
    shot_tick();
    pos("hit_frozen", 10'd140, 10'd201);
    pix("hit_af3", 10'd142, 10'd202, 1'b1, 16'h3042);
    ticks(29);
    pos("hit_29", 10'd140, 10'd201);
    do_tick();                                   // enter FALL
    pos("fall0", 10'd140, 10'd201);
    pix("fall_af4", 10'd142, 10'd202, 1'b1, 16'h4042);
    ticks(3);
    pos("fall3", 10'd140, 10'd210);
    pix("fall3_af", 10'd140, 10'd210, 1'b1, 16'h4000);
    do_tick();
    pos("fall4", 10'd140, 10'd213);
    pix("fall4_af", 10'd140, 10'd213, 1'b1, 16'h5000);
    ticks(4);
    pos("fall8", 10'd140, 10'd225);
    pix("fall8_af", 10'd140, 10'd225, 1'b1, 16'h4000);
    n = 8;
    while (dead_cnt == 0 && n < 150) begin
      do_tick();
      n++;
    end
    check("fall_ticks", n, 72);
    check("dead_pulses", dead_cnt, 1);
    pos("dead", 10'd140, 10'd416);
    check("dead_no_esc", esc_cnt, 1);
    pix("dead_idle", 10'd140, 10'd416, 1'b0, 16'h0);

    // Shot in IDLE is ignored; duck 3 spawns flying right
    pulse_shot();
    pix("idle_shot", 10'd140, 10'd416, 1'b0, 16'h0);
    do_tick();
    do_tick();
    pos("fly3", 10'd290, 10'd415);

    // Shot without tick, then asynchronous reset mid-HIT
    pulse_shot();
    pix("hit3_af3", 10'd290, 10'd415, 1'b1, 16'h3000);
    ticks(5);
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    pos("async_rst", 10'd288, 10'd416);
    check("async_is_duck", is_duck, 1'b0);
    check("async_addr", duck_addr, 16'h0);
    @(negedge Clk);
    Reset = 1'b0;
    pix("post_rst_idle", 10'd288, 10'd416, 1'b0, 16'h0);
    check("rst_no_dead", dead_cnt, 1);
    do_tick();
    do_tick();
    pos("fly_after_rst", 10'd290, 10'd415);

    // Duck 4 after reset: game over mid-FLY forces IDLE without events
    ticks(3);
    pos("k4", 10'd296, 10'd412);
    @(negedge Clk); state = 2'b11;
    @(negedge Clk);
    pix("over_pix", 10'd296, 10'd412, 1'b0, 16'h0);
    do_tick();
    pix("over_tick", 10'd296, 10'd412, 1'b0, 16'h0);
    check("over_no_esc", esc_cnt, 1);
    check("over_no_dead", dead_cnt, 1);
    state = 2'b10;
    do_tick();
    pos("spawn5", 10'd288, 10'd416);
    do_tick();
    pos("fly5_left", 10'd286, 10'd415);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
